// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (IF) and load/store (DM).
// Define ARB_PERF_EN to add grant and conflict counters.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_ack,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [DW/8-1:0] dm_be,
    input  logic [AW-1:0]   dm_addr,
    input  logic [DW-1:0]   dm_wdata,
    output logic [DW-1:0]   dm_rdata,
    output logic            dm_ack,
    output logic            mem_en,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    output logic            busy
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]     perf_if_grants,
    output logic [31:0]     perf_dm_grants,
    output logic [31:0]     perf_conflicts
`endif
);

    localparam int BW = DW / 8;
    localparam int LW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
    localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_e;

    state_e state_q, state_d;
    logic owner_q, owner_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [LW-1:0] lat_q, lat_d;
    logic mem_en_q, mem_en_d;
    logic mem_we_q, mem_we_d;
    logic [BW-1:0] mem_be_q, mem_be_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic if_ack_q, if_ack_d;
    logic dm_ack_q, dm_ack_d;
    logic busy_q, busy_d;

    logic conflict, pick_if, pick_dm;

    // IF only beats DM once it has lost STARVE_MAX conflicts in a row
    assign conflict = (state_q == S_IDLE) && if_req && dm_req;
    assign pick_if  = (state_q == S_IDLE) && if_req &&
                      (!dm_req || (starve_q == SW'(STARVE_MAX)));
    assign pick_dm  = (state_q == S_IDLE) && dm_req && !pick_if;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        lat_d       = lat_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pick_if) begin
                    owner_d    = 1'b0;
                    starve_d   = '0;
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_be_d   = '1;
                    mem_addr_d = if_addr;
                    state_d    = S_ISSUE;
                end else if (pick_dm) begin
                    owner_d     = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_we;
                    mem_be_d    = dm_be;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    state_d     = S_ISSUE;
                    if (conflict) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                mem_we_d = 1'b0;
                lat_d    = LW'(1);
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == LW'(MEM_LAT)) begin
                    if (owner_q) begin
                        dm_rdata_d = mem_rdata;
                        dm_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata;
                        if_ack_d   = 1'b1;
                    end
                    state_d = S_ACK;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            starve_q    <= '0;
            lat_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            lat_q       <= lat_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign busy      = busy_q;

`ifdef ARB_PERF_EN
    logic [31:0] perf_if_q, perf_if_d;
    logic [31:0] perf_dm_q, perf_dm_d;
    logic [31:0] perf_cf_q, perf_cf_d;

    always_comb begin
        perf_if_d = perf_if_q;
        perf_dm_d = perf_dm_q;
        perf_cf_d = perf_cf_q;
        if (pick_if) perf_if_d = perf_if_q + 32'd1;
        if (pick_dm) perf_dm_d = perf_dm_q + 32'd1;
        if (conflict) perf_cf_d = perf_cf_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_if_q <= '0;
            perf_dm_q <= '0;
            perf_cf_q <= '0;
        end else begin
            perf_if_q <= perf_if_d;
            perf_dm_q <= perf_dm_d;
            perf_cf_q <= perf_cf_d;
        end
    end

    assign perf_if_grants = perf_if_q;
    assign perf_dm_grants = perf_dm_q;
    assign perf_conflicts = perf_cf_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, corner sequences, random vs model.
// Perf counter checks are compiled in when ARB_PERF_EN is defined.
module tb_mem_port_arbiter;

    localparam int L    = 1;
    localparam int SMAX = 3;

    logic clk, rst;
    logic if_req, if_ack, dm_req, dm_we, dm_ack;
    logic mem_en, mem_we, busy;
    logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0] dm_be, mem_be;

    logic f_if_req, f_if_ack, f_dm_req, f_dm_we, f_dm_ack;
    logic f_mem_en, f_mem_we, f_busy;
    logic [31:0] f_if_addr, f_if_rdata, f_dm_addr, f_dm_wdata, f_dm_rdata;
    logic [31:0] f_mem_addr, f_mem_wdata, f_mem_rdata;
    logic [3:0] f_dm_be, f_mem_be;

`ifdef ARB_PERF_EN
    logic [31:0] perf_if, perf_dm, perf_cf;
    logic [31:0] f_perf_if, f_perf_dm, f_perf_cf;
`endif

    mem_port_arbiter #(.MEM_LAT(L), .STARVE_MAX(SMAX)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
`ifdef ARB_PERF_EN
        ,
        .perf_if_grants(perf_if),
        .perf_dm_grants(perf_dm),
        .perf_conflicts(perf_cf)
`endif
    );

    mem_port_arbiter #(.MEM_LAT(4), .STARVE_MAX(SMAX)) u_dut4 (
        .clk(clk), .rst(rst),
        .if_req(f_if_req), .if_addr(f_if_addr),
        .if_rdata(f_if_rdata), .if_ack(f_if_ack),
        .dm_req(f_dm_req), .dm_we(f_dm_we), .dm_be(f_dm_be),
        .dm_addr(f_dm_addr), .dm_wdata(f_dm_wdata),
        .dm_rdata(f_dm_rdata), .dm_ack(f_dm_ack),
        .mem_en(f_mem_en), .mem_we(f_mem_we), .mem_be(f_mem_be),
        .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
        .mem_rdata(f_mem_rdata), .busy(f_busy)
`ifdef ARB_PERF_EN
        ,
        .perf_if_grants(f_perf_if),
        .perf_dm_grants(f_perf_dm),
        .perf_conflicts(f_perf_cf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        end
        return r;
    endfunction

    // Memory device for u_dut: 16 words, read data valid L cycles after mem_en
    logic [31:0] mem_arr [16];
    bit          sv [64];
    logic [31:0] sd [64];
    int          mcyc = 0;

    always @(negedge clk) begin
        int s;
        if (mem_en === 1'b1) begin
            if (mem_we) begin
                mem_arr[mem_addr[5:2]] = merge(mem_arr[mem_addr[5:2]],
                                               mem_wdata, mem_be);
            end
            s = (mcyc + L) % 64;
            sv[s] = 1'b1;
            sd[s] = mem_arr[mem_addr[5:2]];
        end
        s = mcyc % 64;
        if (sv[s]) begin
            mem_rdata = sd[s];
            sv[s] = 1'b0;
        end else begin
            mem_rdata = $urandom;
        end
        mcyc++;
    end

    typedef struct {
        bit          is_dm;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  exp_be;
        bit          chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [6];

    task automatic run_vec(input vec_t v);
        if (v.is_dm) begin
            dm_req = 1'b1; dm_we = v.we; dm_be = v.be;
            dm_addr = v.addr; dm_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        @(negedge clk);
        chk("vec_en", mem_en, 1);
        chk("vec_addr", mem_addr, v.addr);
        chk("vec_be", mem_be, v.exp_be);
        chk("vec_we", mem_we, v.we);
        if (v.we) chk("vec_wdata", mem_wdata, v.wdata);
        chk("vec_busy", busy, 1);
        repeat (L) begin
            @(negedge clk);
            chk("vec_en_once", mem_en, 0);
            chk("vec_early_ack", {if_ack, dm_ack}, 0);
        end
        @(negedge clk);
        chk("vec_ack", {if_ack, dm_ack}, v.is_dm ? 2'b01 : 2'b10);
        if (v.chk_rd) chk("vec_rdata", v.is_dm ? dm_rdata : if_rdata, v.exp_rd);
        if_req = 1'b0;
        dm_req = 1'b0;
        @(negedge clk);
        chk("vec_idle", busy, 0);
    endtask

    task automatic conflict_round(input bit detail);
        int dm_at, if_at, en_n;
        if_req = 1'b1; if_addr = 32'h10;
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'h3;
        dm_addr = 32'h20; dm_wdata = 32'hAFA6FFFC;
        dm_at = -1; if_at = -1; en_n = 0;
        for (int c = 1; c <= 4 * (L + 3) && if_at < 0; c++) begin
            @(negedge clk);
            if (mem_en) begin
                en_n++;
                if (detail && en_n == 1) begin
                    chk("cf_dm_we", mem_we, 1);
                    chk("cf_dm_be", mem_be, 4'h3);
                    chk("cf_dm_addr", mem_addr, 32'h20);
                end
                if (detail && en_n == 2) begin
                    chk("cf_if_we", mem_we, 0);
                    chk("cf_if_be", mem_be, 4'hF);
                end
            end
            if (dm_ack && dm_at < 0) begin
                dm_at = c;
                dm_req = 1'b0;
            end
            if (if_ack) begin
                if_at = c;
                if_req = 1'b0;
            end
        end
        chk("cf_dm_ack_cyc", dm_at, 2 + L);
        chk("cf_if_gap", if_at - dm_at, L + 3);
        @(negedge clk);
    endtask

    int ref_mem [16];
    logic [31:0] r_mem [16];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, acks, en_n, en_at, ack_at;
        logic [7:0] got;
        logic [31:0] rd;
`ifdef ARB_PERF_EN
        logic [31:0] s_if, s_dm, s_cf;
`endif
        rst = 1'b1;
        if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_be = 0;
        dm_addr = 0; dm_wdata = 0;
        f_if_req = 0; f_if_addr = 0; f_dm_req = 0; f_dm_we = 0;
        f_dm_be = 0; f_dm_addr = 0; f_dm_wdata = 0; f_mem_rdata = 0;
        tbl[0] = '{0, 0, 4'hF, 32'h10, 32'h0, 4'hF, 1, 32'h1064FFFF};
        tbl[1] = '{1, 1, 4'h3, 32'h20, 32'hAFA6FFFC, 4'h3, 0, 32'h0};
        tbl[2] = '{1, 0, 4'hF, 32'h20, 32'h0, 4'hF, 1, 32'h1122FFFC};
        tbl[3] = '{1, 1, 4'hC, 32'h24, 32'hAABBCCDD, 4'hC, 0, 32'h0};
        tbl[4] = '{0, 0, 4'h0, 32'h24, 32'h0, 4'hF, 1, 32'hAABB7788};
        tbl[5] = '{1, 0, 4'h5, 32'h10, 32'h0, 4'h5, 1, 32'h1064FFFF};
        for (int i = 0; i < 16; i++) mem_arr[i] = 32'h0A0B0000 | i;
        mem_arr[4] = 32'h1064FFFF;
        mem_arr[8] = 32'h11223344;
        mem_arr[9] = 32'h55667788;

        repeat (3) @(negedge clk);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_acks", {if_ack, dm_ack}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
`ifdef ARB_PERF_EN
        chk("rst_perf", perf_if | perf_dm | perf_cf, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

`ifdef ARB_PERF_EN
        s_if = perf_if; s_dm = perf_dm; s_cf = perf_cf;
`endif
        for (int r = 0; r < 5; r++) conflict_round(r == 0);
`ifdef ARB_PERF_EN
        chk("perf_conflicts", perf_cf - s_cf, 5);
        chk("perf_grants", (perf_if - s_if) + (perf_dm - s_dm), 10);
`endif

        // Both held: DM wins three conflicts, then IF gets one
        if_req = 1'b1; if_addr = 32'h18;
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h1C;
        n = 0; got = 0;
        for (int c = 0; c < 8 * (L + 3) + 8 && n < 8; c++) begin
            @(negedge clk);
            if (if_ack || dm_ack) begin
                got[n] = dm_ack;
                n++;
                if (n == 8) begin
                    if_req = 1'b0;
                    dm_req = 1'b0;
                end
            end
        end
        chk("starve_count", n, 8);
        chk("starve_order", got, 8'b0111_0111);
        @(negedge clk);

        // Reset while the access sits in WAIT
        if_req = 1'b1; if_addr = 32'h14;
        repeat (2) @(negedge clk);
        chk("abort_pre_busy", busy, 1);
        rst = 1'b1;
        if_req = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_mem_en", mem_en, 0);
        chk("abort_acks", {if_ack, dm_ack}, 0);
        chk("abort_if_rdata", if_rdata, 0);
        chk("abort_dm_rdata", dm_rdata, 0);
        chk("abort_mem_addr", mem_addr, 0);
`ifdef ARB_PERF_EN
        chk("abort_perf", perf_if | perf_dm | perf_cf, 0);
`endif
        rst = 1'b0;
        acks = 0;
        repeat (2 * (L + 3)) begin
            @(negedge clk);
            if (if_ack || dm_ack) acks++;
        end
        chk("abort_no_ack", acks, 0);
        run_vec(tbl[0]);

        // MEM_LAT=4 instance: memory data valid only in cycle t+5
        f_dm_req = 1'b1; f_dm_we = 1'b0; f_dm_be = 4'hF; f_dm_addr = 32'h8;
        en_n = 0; en_at = -1; ack_at = -1; rd = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (f_mem_en) begin
                en_n++;
                en_at = c;
                chk("l4_addr", f_mem_addr, 32'h8);
            end
            if (f_dm_ack && ack_at < 0) begin
                ack_at = c;
                rd = f_dm_rdata;
                f_dm_req = 1'b0;
            end
            f_mem_rdata = (c == 5) ? 32'hCAFEF00D : (32'h0BAD0000 | c);
        end
        chk("l4_en_count", en_n, 1);
        chk("l4_en_cyc", en_at, 1);
        chk("l4_ack_cyc", ack_at, 6);
        chk("l4_rdata", rd, 32'hCAFEF00D);
        chk("l4_idle", f_busy, 0);

        // Random traffic against a timing/arbitration reference model
        begin
            int k, nxt, p_en, p_ack, starve_m, c_if, c_dm, c_cf, idx;
            bit pend, p_dm, p_we, if_act, dm_act, e_en, e_ia, e_da;
            logic [31:0] p_addr, p_wd, p_rd;
            logic [3:0] p_be;
            for (int i = 0; i < 16; i++) begin
                r_mem[i] = $urandom;
                mem_arr[i] = r_mem[i];
            end
            k = 0; nxt = 0; pend = 0; starve_m = 0;
            c_if = 0; c_dm = 0; c_cf = 0; if_act = 0; dm_act = 0;
            p_en = 0; p_ack = 0; p_dm = 0; p_we = 0;
            p_addr = 0; p_wd = 0; p_rd = 0; p_be = 0;
`ifdef ARB_PERF_EN
            s_if = perf_if; s_dm = perf_dm; s_cf = perf_cf;
`endif
            for (int it = 0; it < 2000; it++) begin
                e_en = pend && k == p_en;
                chk("rnd_en", mem_en, e_en);
                if (e_en) begin
                    chk("rnd_addr", mem_addr, p_addr);
                    chk("rnd_be", mem_be, p_be);
                    chk("rnd_we", mem_we, p_we);
                    if (p_we) chk("rnd_wdata", mem_wdata, p_wd);
                end
                e_ia = pend && k == p_ack && !p_dm;
                e_da = pend && k == p_ack && p_dm;
                chk("rnd_acks", {if_ack, dm_ack}, {e_ia, e_da});
                if ((e_ia || e_da) && !p_we)
                    chk("rnd_rdata", p_dm ? dm_rdata : if_rdata, p_rd);
                chk("rnd_busy", busy, pend && k >= p_en && k <= p_ack);
                if (pend && k == p_ack) begin
                    pend = 0;
                    if (p_dm) dm_act = 0;
                    else if_act = 0;
                end
                if (!if_act && $urandom_range(0, 1) == 1) begin
                    if_act = 1;
                    if_addr = $urandom_range(0, 15) * 4;
                end
                if (!dm_act && $urandom_range(0, 9) < 7) begin
                    dm_act = 1;
                    dm_we = $urandom_range(0, 1);
                    dm_be = $urandom_range(0, 15);
                    dm_addr = $urandom_range(0, 15) * 4;
                    dm_wdata = $urandom;
                end
                if_req = if_act;
                dm_req = dm_act;
                if (k == nxt) begin
                    if (if_req || dm_req) begin
                        if (if_req && dm_req) c_cf++;
                        p_dm = dm_req && !(if_req && starve_m == SMAX);
                        if (!p_dm) starve_m = 0;
                        else if (if_req) starve_m++;
                        pend = 1;
                        p_en = k + 1;
                        p_ack = k + 2 + L;
                        nxt = k + 3 + L;
                        if (p_dm) begin
                            p_we = dm_we; p_be = dm_be;
                            p_addr = dm_addr; p_wd = dm_wdata;
                            c_dm++;
                        end else begin
                            p_we = 0; p_be = 4'hF;
                            p_addr = if_addr; p_wd = 0;
                            c_if++;
                        end
                        idx = int'(p_addr[5:2]);
                        if (p_we) r_mem[idx] = merge(r_mem[idx], p_wd, p_be);
                        p_rd = r_mem[idx];
                    end else begin
                        nxt = k + 1;
                    end
                end
                @(negedge clk);
                k++;
            end
            chk("rnd_starve_bound", starve_m <= SMAX, 1);
`ifdef ARB_PERF_EN
            chk("rnd_perf_if", perf_if - s_if, c_if);
            chk("rnd_perf_dm", perf_dm - s_dm, c_dm);
            chk("rnd_perf_cf", perf_cf - s_cf, c_cf);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
